// File: rtl/i2s_frame_ctrl.sv
// Frame-level scheduler moving stereo pairs between the DSP streams and the I2S parallel ports.
// Optional build macro I2S_FRAME_CTRL_MUTE_EN: output silence on TX underrun instead of repeating.
module i2s_frame_ctrl #(
   parameter int PDATA_WIDTH = 32,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   mclk_in,
   input  logic                   rst_in,
   input  logic                   enable_in,
   input  logic                   lrck_in,
   input  logic                   sclk_in,
   input  logic                   tx_valid_in,
   output logic                   tx_ready_out,
   input  logic [PDATA_WIDTH-1:0] tx_ldata_in,
   input  logic [PDATA_WIDTH-1:0] tx_rdata_in,
   output logic [PDATA_WIDTH-1:0] pldata_out,
   output logic [PDATA_WIDTH-1:0] prdata_out,
   input  logic [PDATA_WIDTH-1:0] pldata_in,
   input  logic [PDATA_WIDTH-1:0] prdata_in,
   output logic                   rx_valid_out,
   input  logic                   rx_ready_in,
   output logic [PDATA_WIDTH-1:0] rx_ldata_out,
   output logic [PDATA_WIDTH-1:0] rx_rdata_out,
   output logic                   frame_tick_out,
   output logic                   running_out,
   input  logic                   cnt_clr_in,
   output logic [CNT_WIDTH-1:0]   underrun_cnt_out,
   output logic [CNT_WIDTH-1:0]   overrun_cnt_out
);

`ifdef I2S_FRAME_CTRL_MUTE_EN
   localparam bit MUTE = 1'b1;
`else
   localparam bit MUTE = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, SYNC, RUN, DRAIN} state_t;

   state_t                 state, state_nx;
   logic                   lrck_q;
   logic                   stage_v, stage_v_nx;
   logic [PDATA_WIDTH-1:0] stage_l, stage_r;
   logic                   fall, rise, active, accept, commit, capture, underrun, overrun;
   logic                   unused_sclk;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic inc, input logic clr);
      if (clr)
         return '0;
      if (inc && (cnt != {CNT_WIDTH{1'b1}}))
         return cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      return cnt;
   endfunction

   assign unused_sclk = sclk_in;

   // LRCK falling edge starts a frame; the rising edge is the TX commit point.
   assign fall     = lrck_q & ~lrck_in;
   assign rise     = ~lrck_q & lrck_in;
   assign active   = (state == RUN) || (state == DRAIN);
   assign accept   = tx_valid_in & tx_ready_out;
   assign commit   = active & rise;
   assign capture  = active & fall;
   assign underrun = commit & ~stage_v;
   assign overrun  = capture & rx_valid_out & ~rx_ready_in;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (enable_in)  state_nx = SYNC;
         SYNC:    if (fall)       state_nx = RUN;
         RUN:     if (!enable_in) state_nx = DRAIN;
         DRAIN:   if (fall)       state_nx = IDLE;
         default:                 state_nx = IDLE;
      endcase

      // A same-cycle accept into an empty stage still leaves the commit as an underrun.
      stage_v_nx = stage_v;
      if ((state == DRAIN) && fall)
         stage_v_nx = 1'b0;
      else if (commit && stage_v)
         stage_v_nx = 1'b0;
      else if (accept)
         stage_v_nx = 1'b1;
   end

   always_ff @(posedge mclk_in) begin
      if (rst_in) begin
         state            <= IDLE;
         lrck_q           <= 1'b0;
         stage_v          <= 1'b0;
         stage_l          <= '0;
         stage_r          <= '0;
         tx_ready_out     <= 1'b0;
         pldata_out       <= '0;
         prdata_out       <= '0;
         rx_valid_out     <= 1'b0;
         rx_ldata_out     <= '0;
         rx_rdata_out     <= '0;
         frame_tick_out   <= 1'b0;
         running_out      <= 1'b0;
         underrun_cnt_out <= '0;
         overrun_cnt_out  <= '0;
      end else begin
         state          <= state_nx;
         lrck_q         <= lrck_in;
         stage_v        <= stage_v_nx;
         frame_tick_out <= fall;
         running_out    <= (state_nx == RUN) || (state_nx == DRAIN);
         tx_ready_out   <= ((state_nx == SYNC) || (state_nx == RUN)) && !stage_v_nx;

         if (accept) begin
            stage_l <= tx_ldata_in;
            stage_r <= tx_rdata_in;
         end

         if (commit && stage_v) begin
            pldata_out <= stage_l;
            prdata_out <= stage_r;
         end else if (underrun && MUTE) begin
            pldata_out <= '0;
            prdata_out <= '0;
         end

         if (capture) begin
            rx_valid_out <= 1'b1;
            rx_ldata_out <= pldata_in;
            rx_rdata_out <= prdata_in;
         end else if (rx_valid_out && rx_ready_in) begin
            rx_valid_out <= 1'b0;
         end

         underrun_cnt_out <= sat_inc(underrun_cnt_out, underrun, cnt_clr_in);
         overrun_cnt_out  <= sat_inc(overrun_cnt_out, overrun, cnt_clr_in);
      end
   end

endmodule
